// File: rtl/ets_capture_engine.sv
// Equivalent-time-sampling capture engine: accumulates interleaved phase bins per
// delay-line step, advances the delay line, then streams the bins over AXI-Stream.

module ets_acc_lane #(
  parameter int ACC_WIDTH = 32
) (
  input  logic                 sample_clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 bit_in,
  output logic [ACC_WIDTH-1:0] acc_q
);
  logic [ACC_WIDTH-1:0] acc_d;

  // Saturating increment: a full bin holds its value instead of wrapping.
  always_comb begin
    acc_d = acc_q;
    if (clr)                            acc_d = '0;
    else if (en && bit_in && acc_q != '1) acc_d = acc_q + ACC_WIDTH'(1);
  end

  always_ff @(posedge sample_clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
endmodule

module ets_capture_engine #(
  parameter int NUM_PHASES = 10,
  parameter int ACC_WIDTH  = 32,
  parameter int STEP_WIDTH = 16,
  parameter int AVG_WIDTH  = 16
) (
  input  logic                  sample_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [STEP_WIDTH-1:0] cfg_steps,
  input  logic [AVG_WIDTH-1:0]  cfg_avg,
  input  logic                  cmp_data,
  output logic                  shift_req,
  input  logic                  shift_done,
  output logic [ACC_WIDTH-1:0]  m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [STEP_WIDTH-1:0] step_idx
);
  localparam int BW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_SAMP   = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_STREAM = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [STEP_WIDTH-1:0] steps_q, steps_d;
  logic [AVG_WIDTH-1:0]  avg_q, avg_d;
  logic [STEP_WIDTH-1:0] step_idx_q, step_idx_d;
  logic [NUM_PHASES-1:0] token_q, token_d;
  logic [AVG_WIDTH-1:0]  rot_q, rot_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  abort_pend_q, abort_pend_d;
  logic                  done_q, done_d;

  logic [NUM_PHASES-1:0][ACC_WIDTH-1:0] acc_q;
  logic [NUM_PHASES-1:0]                acc_en;
  logic                                 acc_clr;

  assign acc_clr = (state_q == S_ARM);

  for (genvar k = 0; k < NUM_PHASES; k++) begin : g_lane
    assign acc_en[k] = (state_q == S_SAMP) && token_q[k];
    ets_acc_lane #(.ACC_WIDTH(ACC_WIDTH)) u_lane (
      .sample_clk (sample_clk),
      .rst_n      (rst_n),
      .clr        (acc_clr),
      .en         (acc_en[k]),
      .bit_in     (cmp_data),
      .acc_q      (acc_q[k])
    );
  end

  logic last_beat, final_step, samp_end, streaming, hs, stop_req;

  assign last_beat  = (beat_q == BW'(NUM_PHASES - 1));
  assign final_step = (step_idx_q == steps_q - STEP_WIDTH'(1));
  assign samp_end   = token_q[NUM_PHASES-1] && (rot_q == avg_q - AVG_WIDTH'(1));
  assign streaming  = (state_q == S_STREAM);
  assign hs         = streaming && m_tready;
  assign stop_req   = abort || abort_pend_q;

  always_comb begin
    state_d      = state_q;
    steps_d      = steps_q;
    avg_d        = avg_q;
    step_idx_d   = step_idx_q;
    token_d      = token_q;
    rot_d        = rot_q;
    beat_d       = beat_q;
    abort_pend_d = abort_pend_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        abort_pend_d = 1'b0;
        if (start && !abort) begin
          steps_d    = (cfg_steps == '0) ? STEP_WIDTH'(1) : cfg_steps;
          avg_d      = (cfg_avg == '0) ? AVG_WIDTH'(1) : cfg_avg;
          step_idx_d = '0;
          state_d    = S_ARM;
        end
      end
      S_ARM: begin
        rot_d   = '0;
        token_d = NUM_PHASES'(1);
        state_d = S_SAMP;
      end
      S_SAMP: begin
        token_d = {token_q[NUM_PHASES-2:0], token_q[NUM_PHASES-1]};
        if (token_q[NUM_PHASES-1]) rot_d = rot_q + AVG_WIDTH'(1);
        if (samp_end) state_d = S_SHIFT;
      end
      S_SHIFT: state_d = S_WAIT;
      S_WAIT: begin
        if (shift_done) begin
          beat_d  = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (abort) abort_pend_d = 1'b1;
        if (hs) begin
          if (stop_req || (last_beat && final_step)) begin
            abort_pend_d = 1'b0;
            done_d       = 1'b1;
            state_d      = S_IDLE;
          end else if (last_beat) begin
            step_idx_d = step_idx_q + STEP_WIDTH'(1);
            state_d    = S_ARM;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outside the stream an abort drops the capture at once.
    if (abort && (state_q == S_ARM || state_q == S_SAMP ||
                  state_q == S_SHIFT || state_q == S_WAIT)) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge sample_clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= S_IDLE;
      steps_q      <= '0;
      avg_q        <= '0;
      step_idx_q   <= '0;
      token_q      <= NUM_PHASES'(1);
      rot_q        <= '0;
      beat_q       <= '0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_q      <= steps_d;
      avg_q        <= avg_d;
      step_idx_q   <= step_idx_d;
      token_q      <= token_d;
      rot_q        <= rot_d;
      beat_q       <= beat_d;
      abort_pend_q <= abort_pend_d;
      done_q       <= done_d;
    end

  // A pending abort turns the current beat into the frame's last one.
  assign m_tvalid  = streaming;
  assign m_tdata   = streaming ? acc_q[beat_q] : '0;
  assign m_tlast   = streaming && ((last_beat && final_step) || stop_req);
  assign shift_req = (state_q == S_SHIFT);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign step_idx  = step_idx_q;
endmodule
